// File: rtl/spi_slave_if.sv
// Serial-side and parallel-side signals of the AES SPI responder.
// The initiator/bench holds the master modport; spi_slave holds the slave modport.
interface spi_slave_if #(
  parameter int unsigned datasize = 128
);
  logic                sclk;
  logic                cs;
  logic                mosi;
  logic                miso;
  logic [datasize-1:0] tx_data;
  logic [datasize-1:0] rx_data;
  logic                rx_valid;
  logic                busy;
  logic                frame_err;

  modport master (
    output sclk, cs, mosi, tx_data,
    input  miso, rx_data, rx_valid, busy, frame_err
  );

  modport slave (
    input  sclk, cs, mosi, tx_data,
    output miso, rx_data, rx_valid, busy, frame_err
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first: oversamples SCLK/CS/MOSI on clk, receives one
// datasize-bit block per CS-low frame and returns tx_data on MISO in the same frame.
module spi_slave #(
  parameter int unsigned datasize = 128
) (
  input logic       clk,
  input logic       rst,
  spi_slave_if.slave bus
);
  localparam int unsigned CW = $clog2(datasize + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_d;

  logic sclk_s1, sclk_s2, sclk_s3;
  logic cs_s1, cs_s2, cs_s3;
  logic mosi_s1, mosi_s2;
  logic [2:0] warm;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, last_rise;

  logic [CW-1:0]       cnt, cnt_d;
  logic [datasize-2:0] rx_sh, rx_sh_d;
  logic [datasize-2:0] tx_sh, tx_sh_d;
  logic                miso_q, miso_d;
  logic [datasize-1:0] rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                frame_err_q, frame_err_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_s1 <= 1'b0; sclk_s2 <= 1'b0; sclk_s3 <= 1'b0;
      cs_s1   <= 1'b1; cs_s2   <= 1'b1; cs_s3   <= 1'b1;
      mosi_s1 <= 1'b0; mosi_s2 <= 1'b0;
      warm    <= '0;
    end else begin
      sclk_s1 <= bus.sclk; sclk_s2 <= sclk_s1; sclk_s3 <= sclk_s2;
      cs_s1   <= bus.cs;   cs_s2   <= cs_s1;   cs_s3   <= cs_s2;
      mosi_s1 <= bus.mosi; mosi_s2 <= mosi_s1;
      warm    <= {warm[1:0], 1'b1};
    end
  end

  // cs_s3 holds a reset value, not a real sample, until warm[2]; this stops a
  // CS already low at reset release from looking like a fresh frame start.
  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign sclk_fall = ~sclk_s2 & sclk_s3;
  assign cs_fall   = ~cs_s2 & cs_s3 & warm[2];
  assign cs_rise   = cs_s2 & ~cs_s3;
  assign last_rise = sclk_rise && (cnt == CW'(datasize - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    rx_sh_d     = rx_sh;
    tx_sh_d     = tx_sh;
    miso_d      = miso_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          tx_sh_d = bus.tx_data[datasize-2:0];
          miso_d  = bus.tx_data[datasize-1];
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // The final capture outranks a coincident cs_rise; cs_s2 then tells
        // whether CS is already released so DONE can be skipped.
        if (last_rise) begin
          cnt_d      = cnt + CW'(1);
          rx_data_d  = {rx_sh, mosi_s2};
          rx_valid_d = 1'b1;
          miso_d     = 1'b0;
          state_d    = cs_s2 ? IDLE : DONE;
        end else if (cs_rise) begin
          frame_err_d = 1'b1;
          miso_d      = 1'b0;
          state_d     = IDLE;
        end else if (sclk_rise) begin
          rx_sh_d    = rx_sh << 1;
          rx_sh_d[0] = mosi_s2;
          cnt_d      = cnt + CW'(1);
        end else if (sclk_fall) begin
          miso_d  = tx_sh[datasize-2];
          tx_sh_d = tx_sh << 1;
        end
      end
      DONE: begin
        miso_d = 1'b0;
        if (cs_rise) state_d = IDLE;
      end
      default: begin
        miso_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      rx_sh       <= '0;
      tx_sh       <= '0;
      miso_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      cnt         <= cnt_d;
      rx_sh       <= rx_sh_d;
      tx_sh       <= tx_sh_d;
      miso_q      <= miso_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.miso      = miso_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state == SHIFT);
endmodule
